// File: rtl/sram_responder_pkg.sv
// Shared types and constants for the SRAM-bus responder.
// The optional random-wait feature is enabled by defining SRAM_RESP_LFSR_EN.
package sram_responder_pkg;

    localparam int DW    = 32;
    localparam int NLANE = DW / 8;

    localparam logic [15:0] SRAM_RESP_LFSR_SEED = 16'hACE1;

    typedef enum logic {
        SRAM_RESP_IDLE = 1'b0,
        SRAM_RESP_BUSY = 1'b1
    } state_t;

    // One step of the 16-bit Fibonacci LFSR, taps 16,14,13,11 (right-shifting form)
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic fb;
        fb = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {fb, l[15:1]};
    endfunction

endpackage

// File: rtl/sram_responder_if.sv
// SRAM-like request/response bus between the pipeline core (master) and memory (slave).
interface sram_responder_if;
    import sram_responder_pkg::*;

    logic             sram_en;
    logic [NLANE-1:0] sram_we;
    logic [DW-1:0]    sram_addr;
    logic [DW-1:0]    sram_wdata;
    logic [DW-1:0]    sram_rdata;
    logic             stallreq_outside;

    modport master (
        output sram_en, sram_we, sram_addr, sram_wdata,
        input  sram_rdata, stallreq_outside
    );

    modport slave (
        input  sram_en, sram_we, sram_addr, sram_wdata,
        output sram_rdata, stallreq_outside
    );
endinterface

// File: rtl/sram_resp_array.sv
// 2**AW x 32 word RAM: one byte-enabled write port, one registered read port.
module sram_resp_array
    import sram_responder_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NLANE-1:0] i_we,
    input  logic             i_re,
    input  logic [AW-1:0]    i_addr,
    input  logic [DW-1:0]    i_wdata,
    output logic [DW-1:0]    o_rdata
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_q;

    // Byte-lane write; contents are never cleared
    always_ff @(posedge clk) begin
        for (int i = 0; i < NLANE; i++) begin
            if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
    end

    // Registered read, holds its value until the next read
    always_ff @(posedge clk) begin
        if (rst)       r_q <= '0;
        else if (i_re) r_q <= r_mem[i_addr];
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/sram_responder.sv
// Slave end of the SRAM-like bus: word RAM with byte-lane writes and wait states.
// Define SRAM_RESP_LFSR_EN to draw a 0..3 wait count per access from an LFSR
// instead of the fixed WAIT parameter.
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int          AW     = 10,
    parameter int          WAIT   = 0,
    parameter logic [31:0] OOB_RD = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    sram_responder_if.slave   bus,
    output logic [15:0]       oob_cnt
);

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic [3:0]       w_wait_n;
    logic [NLANE-1:0] r_we;
    logic [DW-1:0]    r_addr, r_wdata;
    logic [NLANE-1:0] w_acc_we;
    logic [DW-1:0]    w_acc_addr, w_acc_wdata;
    logic             w_accept, w_do, w_oob, w_rd;
    logic             r_stall, r_oob_rd;
    logic [15:0]      r_oob_cnt;
    logic [DW-1:0]    w_arr_q;
    logic             w_unused_lsb;

    assign w_accept = (r_state == SRAM_RESP_IDLE) && bus.sram_en;

`ifdef SRAM_RESP_LFSR_EN
    logic [15:0] r_lfsr;

    // LFSR steps once per accepted request; its low bits set that request's wait
    always_ff @(posedge clk) begin
        if (rst)           r_lfsr <= SRAM_RESP_LFSR_SEED;
        else if (w_accept) r_lfsr <= lfsr_step(r_lfsr);
    end

    assign w_wait_n = {2'b00, r_lfsr[1:0]};
`else
    assign w_wait_n = 4'(WAIT);
`endif

    // State, wait counter and stall flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SRAM_RESP_IDLE;
            r_cnt   <= '0;
            r_stall <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_stall <= (w_state_nxt == SRAM_RESP_BUSY);
        end
    end

    // Latch the request on accept; BUSY replays it from here
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= bus.sram_we;
            r_addr  <= bus.sram_addr;
            r_wdata <= bus.sram_wdata;
        end
    end

    // Next state and which access (live or latched) is performed this edge
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_do        = 1'b0;
        w_acc_we    = r_we;
        w_acc_addr  = r_addr;
        w_acc_wdata = r_wdata;
        case (r_state)
            SRAM_RESP_IDLE: begin
                w_acc_we    = bus.sram_we;
                w_acc_addr  = bus.sram_addr;
                w_acc_wdata = bus.sram_wdata;
                if (bus.sram_en) begin
                    if (w_wait_n == 4'd0) begin
                        w_do = 1'b1;
                    end else begin
                        w_state_nxt = SRAM_RESP_BUSY;
                        w_cnt_nxt   = w_wait_n;
                    end
                end
            end
            SRAM_RESP_BUSY: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_do        = 1'b1;
                    w_state_nxt = SRAM_RESP_IDLE;
                end
            end
            default: w_state_nxt = SRAM_RESP_IDLE;
        endcase
    end

    assign w_oob        = (w_acc_addr[DW-1:AW+2] != '0);
    assign w_rd         = w_do && (w_acc_we == '0);
    assign w_unused_lsb = ^w_acc_addr[1:0];

    sram_resp_array #(.AW(AW)) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    ((w_do && !w_oob) ? w_acc_we : '0),
        .i_re    (w_rd && !w_oob),
        .i_addr  (w_acc_addr[AW+1:2]),
        .i_wdata (w_acc_wdata),
        .o_rdata (w_arr_q)
    );

    // Remember whether the last completed read was out of range
    always_ff @(posedge clk) begin
        if (rst)       r_oob_rd <= 1'b0;
        else if (w_rd) r_oob_rd <= w_oob;
    end

    // Saturating out-of-range access counter
    always_ff @(posedge clk) begin
        if (rst)                                     r_oob_cnt <= '0;
        else if (w_do && w_oob && r_oob_cnt != '1)   r_oob_cnt <= r_oob_cnt + 16'd1;
    end

    assign bus.sram_rdata       = r_oob_rd ? OOB_RD : w_arr_q;
    assign bus.stallreq_outside = r_stall;
    assign oob_cnt              = r_oob_cnt;

endmodule
